full_row_scanner: RTL
=====================

FULL_ROW_SCANNER -- requirements
Module: full_row_scanner

Interface
REQ-001 SHALL have parameters: BOARD_W, default 10, cells per row; BOARD_H, default 24, rows per board.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port enable, input, 1, level request; a scan starts when enable is high in IDLE.
REQ-005 SHALL have port ram_addr, output, 8, board RAM read address; address = row*BOARD_W + col.
REQ-006 SHALL have port wren, output, 1, RAM write enable; constant 0.
REQ-007 SHALL have port ram_q, input, 6, RAM read data; a cell is occupied when ram_q != 0.
REQ-008 SHALL have port busy, output, 1, high in READ and DRAIN.
REQ-009 SHALL have port complete, output, 1, high in DONE.
REQ-010 SHALL have port full_rows, output, 24, bit r set when all BOARD_W cells of row r are occupied.
REQ-011 SHALL have port full_count, output, 5, number of set bits in full_rows, 0..24.
REQ-012 SHALL have port top_row, output, 5, lowest row index holding any occupied cell; 24 when the board is empty.

Function
REQ-013 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-014 SHALL leave IDLE for READ on the edge sampling enable=1, with ram_addr <= 0 on that edge (edge 0).
REQ-015 SHALL advance ram_addr by 1 per edge in READ, reaching 239 at edge 239, then enter DRAIN.
REQ-016 SHALL generate addresses from row/col counters (col wraps 9->0, row increments); no multiplier.
REQ-017 SHALL treat RAM read latency as fixed: data for the address driven after edge a is sampled at edge a+2.
REQ-018 SHALL register a two-stage delayed row/col tag alongside the address so every sample is tagged with its row/col.
REQ-019 SHALL keep a per-row AND accumulator, reset at col 0 and committed to the internal row bit at col 9.
REQ-020 SHALL update the internal top_row only on the first occupied sample; later rows never overwrite it.
REQ-021 SHALL sample the last cell (239) at edge 241, then enter DONE at edge 242; the scan takes exactly 242 cycles.
REQ-022 SHALL copy internal results to full_rows/full_count/top_row only on the edge entering DONE.
REQ-023 SHALL clear internal accumulators (rows 0, top_row 24) on the edge leaving IDLE.
REQ-024 SHALL hold DONE, complete=1 and the outputs while enable stays high, with no rescan.
REQ-025 SHALL return to IDLE (complete=0) on the first edge sampling enable=0 in DONE.
REQ-026 SHALL abort to IDLE if enable=0 is sampled in READ or DRAIN, with ram_addr <= 0, busy=0, complete=0.
REQ-027 SHALL leave all result outputs unchanged after an abort, holding the last completed scan.
REQ-028 SHALL compute full_count with a 5-bit accumulator that increments per committed full row and never wraps.

Reset
REQ-029 SHALL, while resetn=0: state IDLE, ram_addr 0, wren 0, busy 0, complete 0, full_rows 0, full_count 0, top_row 24, all counters and accumulators 0.
REQ-030 SHALL abandon any scan on reset mid-operation; no partial result appears on the outputs.

Structure
REQ-031 SHALL place BOARD_W, BOARD_H, CELLS=240, ADDR_W=8, DATA_W=6 and the state encoding in a shared board package.
REQ-032 SHALL implement the row/col address generator as sub-module board_scan_addr, with outputs ram_addr, row, col and last.

Verification
REQ-033 SHALL cover an all-zero RAM with enable held: complete rises after edge 242; full_rows=0, full_count=0, top_row=24.
REQ-034 SHALL cover rows 5 and 23 all 6'h01 plus cell (3,4)=6'h2A: full_rows=24'h800020, full_count=2, top_row=3.
REQ-035 SHALL cover all cells 6'h3F: full_rows=24'hFFFFFF, full_count=24, top_row=0.
REQ-036 SHALL cover row 10 occupied except col 9, and row 11 with only col 0 empty: full_rows=0, full_count=0, top_row=10.
REQ-037 SHALL cover dropping enable at cycle 100 of a scan: busy falls the next edge, complete stays 0, outputs keep the prior scan; re-enable yields a correct result at 242 cycles.
REQ-038 SHALL cover asserting resetn=0 at cycle 150: all outputs take reset values immediately; after release with enable high, a full 242-cycle scan completes.

Source files
------------

// File: rtl/full_row_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_row_scanner_pkg
// Description : Board geometry, RAM widths and scanner state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package full_row_scanner_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 24;
    localparam int CELLS    = BOARD_W * BOARD_H;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 6;
    localparam int ROW_W    = 5;
    localparam int COL_W    = 4;
    localparam int ROWS_MAX = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/board_scan_addr.sv
`default_nettype none
// ============================================================================
// Module      : board_scan_addr
// Description : Row/column counter pair that walks the board RAM linearly.
// Revision    : 1.0  initial release
// ============================================================================
module board_scan_addr
    import full_row_scanner_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              step,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              last
);

    localparam logic [ADDR_W-1:0] c_penult  = ADDR_W'(BOARD_W * BOARD_H - 2);
    localparam logic [COL_W-1:0]  c_col_end = COL_W'(BOARD_W - 1);

    logic [ADDR_W-1:0] r_addr;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (clr) begin
            r_addr <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (step) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_col == c_col_end) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Flags the step that lands on the final cell, so the caller can change
    // state on the same edge that issues the last address.
    assign last     = (r_addr == c_penult);
    assign ram_addr = r_addr;
    assign row      = r_row;
    assign col      = r_col;

endmodule
`default_nettype wire

// File: rtl/full_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : full_row_scanner
// Description : Scans the board RAM once per request and reports full rows,
//               their count and the topmost occupied row.
// Revision    : 1.0  initial release
// ============================================================================
module full_row_scanner #(
    parameter int BOARD_W = full_row_scanner_pkg::BOARD_W,
    parameter int BOARD_H = full_row_scanner_pkg::BOARD_H
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      enable,
    output logic [full_row_scanner_pkg::ADDR_W-1:0]   ram_addr,
    output logic                                      wren,
    input  logic [full_row_scanner_pkg::DATA_W-1:0]   ram_q,
    output logic                                      busy,
    output logic                                      complete,
    output logic [full_row_scanner_pkg::ROWS_MAX-1:0] full_rows,
    output logic [4:0]                                full_count,
    output logic [4:0]                                top_row
);
    import full_row_scanner_pkg::*;

    localparam logic [ROW_W-1:0] c_top_none = ROW_W'(BOARD_H);
    localparam logic [COL_W-1:0] c_col_end  = COL_W'(BOARD_W - 1);

    state_t              r_state;
    logic                r_busy;
    logic                r_complete;
    logic                r_issue;
    logic                r_t_vld;
    logic [ROW_W-1:0]    r_t_row;
    logic [COL_W-1:0]    r_t_col;
    logic                r_acc;
    logic [ROWS_MAX-1:0] r_rows;
    logic [4:0]          r_cnt;
    logic [ROW_W-1:0]    r_top;
    logic [ROWS_MAX-1:0] r_full_rows;
    logic [4:0]          r_full_count;
    logic [ROW_W-1:0]    r_top_row;

    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;
    logic                w_last;
    logic                w_abort;
    logic                w_clr;
    logic                w_step;
    logic                w_occ;
    logic                w_acc;

    assign w_abort = !enable && (r_state == ST_READ || r_state == ST_DRAIN);
    assign w_clr   = (r_state == ST_IDLE) || w_abort;
    assign w_step  = (r_state == ST_READ) && enable;
    assign w_occ   = (ram_q != '0);
    assign w_acc   = (r_t_col == '0) ? w_occ : (r_acc & w_occ);

    board_scan_addr #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_addr (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (w_clr),
        .step     (w_step),
        .ram_addr (ram_addr),
        .row      (w_row),
        .col      (w_col),
        .last     (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_complete   <= 1'b0;
            r_issue      <= 1'b0;
            r_t_vld      <= 1'b0;
            r_t_row      <= '0;
            r_t_col      <= '0;
            r_acc        <= 1'b0;
            r_rows       <= '0;
            r_cnt        <= '0;
            r_top        <= c_top_none;
            r_full_rows  <= '0;
            r_full_count <= '0;
            r_top_row    <= c_top_none;
        end else begin
            // Tag travels one edge behind the address so it meets its data.
            r_t_vld <= r_issue;
            r_t_row <= w_row;
            r_t_col <= w_col;

            if (r_t_vld) begin
                r_acc <= w_acc;
                if (r_t_col == c_col_end) begin
                    r_rows[r_t_row] <= w_acc;
                    if (w_acc && r_cnt != 5'h1F) begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                if (w_occ && r_top == c_top_none) begin
                    r_top <= r_t_row;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_READ;
                        r_busy  <= 1'b1;
                        r_issue <= 1'b1;
                        r_acc   <= 1'b0;
                        r_rows  <= '0;
                        r_cnt   <= '0;
                        r_top   <= c_top_none;
                    end
                end
                ST_READ, ST_DRAIN: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_issue <= 1'b0;
                        r_t_vld <= 1'b0;
                    end else if (r_state == ST_READ) begin
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_issue <= 1'b0;
                        if (!r_issue && !r_t_vld) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_complete   <= 1'b1;
                            r_full_rows  <= r_rows;
                            r_full_count <= r_cnt;
                            r_top_row    <= r_top;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_state    <= ST_IDLE;
                        r_complete <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wren       = 1'b0;
    assign busy       = r_busy;
    assign complete   = r_complete;
    assign full_rows  = r_full_rows;
    assign full_count = r_full_count;
    assign top_row    = r_top_row;

endmodule
`default_nettype wire
